seq_subtractor: RTL and testbench
=================================

// Module: seq_subtractor
// PURPOSE
//  Multi-cycle WIDTH-bit subtractor computing diff = a - b, CHUNK bits per cycle
//   through a ripple borrow chain. It is the inverse-direction companion to the
//   single-cycle 32-bit adder in the pRISC datapath.
//  Reports borrow, zero, negative and signed-overflow flags.
//  Used where a narrow subtract slice is cheaper than a full-width one.
//  Valid/ready handshake on both input and output.
// PARAMETERS
//  WIDTH   32  operand/result width in bits
//  CHUNK   8   bits processed per cycle; WIDTH % CHUNK must be 0 (elaboration error otherwise)
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst_n      in   1      reset, synchronous, active-low
//  in_valid   in   1      operands a/b valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  out_valid  out  1      result and flags valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b, modulo 2^WIDTH
//  borrow     out  1      1 iff a < b (unsigned)
//  zero       out  1      diff == 0
//  neg        out  1      diff[WIDTH-1]
//  ovf        out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, count=0, diff=0, all flags=0,
//   out_valid=0, in_ready=1. Reset wins over any handshake in the same cycle.
//  Reset mid-RUN or in DONE: operation discarded, no result is emitted.
//  States:
//   IDLE: in_ready=1. in_valid=1 latches a, b, sets carry=1 (two's-complement +1),
//    count=0, and moves to RUN.
//   RUN: in_ready=0. Each cycle, chunk k=count computes
//    {c, s} = a[k] + ~b[k] + carry, writes s into diff[k], carry<=c, count++.
//    After chunk NCHUNK-1, moves to DONE and registers the flags.
//   DONE: out_valid=1 with diff and flags held stable.
//    out_ready=1 moves to IDLE; out_valid drops the next cycle.
//  Latency: out_valid rises exactly NCHUNK = WIDTH/CHUNK cycles after the
//   accepting edge (4 for defaults). Minimum issue interval is NCHUNK+2 cycles.
//  borrow = ~final carry. zero and neg come from the completed diff.
//   ovf uses the latched a/b MSBs.
//  in_valid while in_ready=0 is ignored; the operands are not queued.
//  out_ready while out_valid=0 has no effect.
//  out_ready may be held low indefinitely; outputs stay frozen while it is low.
//  diff and flags are visible only while out_valid=1. Their values outside DONE
//   are don't-care to consumers but must stay deterministic (no X after reset).
//  Wrap-around: results are modulo 2^WIDTH. For example, 0 - 1 = all-ones with borrow=1.
//  The count register is $clog2(NCHUNK) bits wide; NCHUNK=1 is legal (single RUN cycle).
// STRUCTURE
//  Shared include prisc_defs.vh: state encodings S_IDLE/S_RUN/S_DONE (2-bit).
//  Local params: NCHUNK=WIDTH/CHUNK, CW=$clog2(NCHUNK) (min 1).
//  Sub-module chunk_sub #(CHUNK): combinational {cout,s} = x + ~y + cin.
//   Instantiated once and muxed by count.
//  Top: FSM, operand registers, diff register with per-chunk write enable,
//   carry register, flag logic.
// TESTING (WIDTH=32, CHUNK=8)
//  a=5, b=3 -> out_valid 4 cycles after accept; diff=2, borrow=0, zero=0, neg=0, ovf=0
//  a=3, b=5 -> diff=0xFFFFFFFE, borrow=1, neg=1, zero=0, ovf=0
//  a=0x80000000, b=1 -> diff=0x7FFFFFFF, ovf=1, borrow=0, neg=0;
//   a=0x7FFFFFFF, b=0xFFFFFFFF -> diff=0x80000000, ovf=1, borrow=1
//  a=b=0x1234ABCD -> diff=0, zero=1, borrow=0; a=0x00000100, b=0x00000001 ->
//   diff=0x000000FF (borrow crosses a chunk boundary)
//  Backpressure: hold out_ready=0 for 10 cycles -> out_valid, diff and flags stable,
//   in_ready=0; in_valid pulses with a=9, b=9 are ignored (next result is not zero)
//  Reset mid-RUN (rst_n=0 at the 2nd RUN cycle) -> next edge: out_valid=0, in_ready=1,
//   diff=0; a new op 7-2 then yields diff=5 with normal latency

Source files
------------

// File: rtl/seq_subtractor_pkg.sv
// seq_subtractor_pkg: shared FSM encoding, flag record and width helper for the multi-cycle subtractor
package seq_subtractor_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic borrow;
        logic zero;
        logic neg;
        logic ovf;
    } flags_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_subtractor_if.sv
// seq_subtractor_if: operand and result valid/ready channels of the multi-cycle subtractor
interface seq_subtractor_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero, neg, ovf
    );
endinterface

// File: rtl/seq_subtractor_chunk_sub.sv
// seq_subtractor_chunk_sub: one CHUNK-bit slice of the borrow chain, {cout, s} = x + ~y + cin
module seq_subtractor_chunk_sub #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x_i,
    input  logic [CHUNK-1:0] y_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] s_o,
    output logic             cout_o
);
    logic [CHUNK-1:0] yn;

    assign yn = ~y_i;
    assign {cout_o, s_o} = {1'b0, x_i} + {1'b0, yn} + {{CHUNK{1'b0}}, cin_i};
endmodule

// File: rtl/seq_subtractor.sv
// seq_subtractor: WIDTH-bit a - b computed CHUNK bits per cycle, with borrow/zero/neg/ovf flags
module seq_subtractor
    import seq_subtractor_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input logic clk,
    input logic rst_n,
    seq_subtractor_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = clog2_min1(NCHUNK);

    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
        $error("seq_subtractor: WIDTH must be a multiple of CHUNK");
    end

    state_e                        state_q, state_d;
    logic [NCHUNK-1:0][CHUNK-1:0]  a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic [CW-1:0]                 count_q, count_d;
    logic                          carry_q, carry_d;
    flags_t                        flags_q, flags_d;
    logic [CHUNK-1:0]              s;
    logic                          cout;
    logic                          last;

    seq_subtractor_chunk_sub #(.CHUNK(CHUNK)) u_chunk (
        .x_i    (a_q[count_q]),
        .y_i    (b_q[count_q]),
        .cin_i  (carry_q),
        .s_o    (s),
        .cout_o (cout)
    );

    assign last = (count_q == CW'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        count_d = count_q;
        carry_d = carry_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: if (bus.in_valid) begin
                a_d     = bus.a;
                b_d     = bus.b;
                carry_d = 1'b1;
                count_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                diff_d[count_q] = s;
                carry_d         = cout;
                count_d         = count_q + 1'b1;
                if (last) begin
                    // flags see the final chunk through diff_d, one cycle before diff_q holds it
                    state_d        = S_DONE;
                    count_d        = '0;
                    flags_d.borrow = ~cout;
                    flags_d.zero   = ~|diff_d;
                    flags_d.neg    = s[CHUNK-1];
                    flags_d.ovf    = (a_q[NCHUNK-1][CHUNK-1] != b_q[NCHUNK-1][CHUNK-1]) &&
                                     (s[CHUNK-1] != a_q[NCHUNK-1][CHUNK-1]);
                end
            end
            S_DONE: state_d = bus.out_ready ? S_IDLE : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            count_q <= '0;
            carry_q <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            count_q <= count_d;
            carry_q <= carry_d;
            flags_q <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = flags_q.borrow;
    assign bus.zero      = flags_q.zero;
    assign bus.neg       = flags_q.neg;
    assign bus.ovf       = flags_q.ovf;
endmodule

// File: tb/tb_seq_subtractor.sv
// tb_seq_subtractor: directed vectors plus backpressure and mid-run reset sequences for seq_subtractor
module tb_seq_subtractor;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] diff;
        logic        borrow;
        logic        zero;
        logic        neg;
        logic        ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   lat;

    seq_subtractor_if #(.WIDTH(32)) bus ();

    seq_subtractor #(.WIDTH(32), .CHUNK(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("in_ready_before_issue", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, 4);
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("out_valid_after_consume", bus.out_valid, 0);
        chk("in_ready_after_consume", bus.in_ready, 1);
    endtask

    task automatic chk_res(input vec_t v);
        chk("diff", bus.diff, v.diff);
        chk("borrow", bus.borrow, v.borrow);
        chk("zero", bus.zero, v.zero);
        chk("neg", bus.neg, v.neg);
        chk("ovf", bus.ovf, v.ovf);
    endtask

    initial begin
        vec_t vecs[9];
        vec_t v;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = '0;
        bus.b = '0;
        vecs[0] = '{32'd5,        32'd3,        32'd2,        1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'd3,        32'd5,        32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h1234ABCD, 32'h1234ABCD, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{32'h00000100, 32'h00000001, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{32'h00010000, 32'h00000001, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_diff", bus.diff, 0);
        chk("rst_flags", {bus.borrow, bus.zero, bus.neg, bus.ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // out_ready while idle must not create a result
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_out_ready_no_effect", bus.out_valid, 0);
        bus.out_ready = 1'b0;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i].a, vecs[i].b);
            chk_res(vecs[i]);
            consume();
        end

        // backpressure: result frozen, in_ready low, 9-9 pulses ignored
        v = '{32'd20, 32'd7, 32'd13, 1'b0, 1'b0, 1'b0, 1'b0};
        issue(v.a, v.b);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = i[0];
            bus.a = 32'd9;
            bus.b = 32'd9;
            @(posedge clk);
            #1;
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_in_ready", bus.in_ready, 0);
            chk_res(v);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        consume();
        repeat (8) @(posedge clk);
        #1;
        chk("no_queued_op", bus.out_valid, 0);
        v = '{32'd10, 32'd4, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0};
        issue(v.a, v.b);
        chk_res(v);
        consume();

        // reset sampled at the second RUN edge discards the operation
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 32'h55555555;
        bus.b = 32'h11111111;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_run_partial_diff", bus.diff[7:0], 8'h44);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_diff", bus.diff, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_no_result", bus.out_valid, 0);
        v = '{32'd7, 32'd2, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        issue(v.a, v.b);
        chk_res(v);
        consume();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
